// File: rtl/nibble_sort_ctrl.sv
// ----------------------------------------------------------------------------
// Module      : nibble_sort_ctrl
// Description : Bubble sort sequencer with early exit, one compare-and-swap
//               per clock through a single borrow-out magnitude comparator.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nibble_sort_ctrl #(
  parameter int N      = 4,
  parameter int W      = 4,
  parameter int SWAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*W-1:0]    din,
  output logic              busy,
  output logic              done,
  output logic [N*W-1:0]    dout,
  output logic [SWAP_W-1:0] swaps
);

  localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [N-1:0][W-1:0]       elem_q, elem_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          pass_q, pass_d;
  logic                      flag_q, flag_d;
  logic [SWAP_W-1:0]         swap_cnt_q, swap_cnt_d;
  logic [N*W-1:0]            dout_q, dout_d;
  logic [SWAP_W-1:0]         swaps_q, swaps_d;

  logic [IDX_W-1:0]          idx_nxt;
  logic [W-1:0]              cmp_in1;
  logic [W-1:0]              cmp_in2;
  logic                      bout;

  assign idx_nxt = idx_q + IDX_W'(1);
  assign cmp_in1 = elem_q[idx_nxt];
  assign cmp_in2 = elem_q[idx_q];
  // Borrow-out of in1 - in2: strictly less-than, so equal values never swap.
  assign bout    = (cmp_in1 < cmp_in2);

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    flag_d     = flag_q;
    swap_cnt_d = swap_cnt_q;
    dout_d     = dout_q;
    swaps_d    = swaps_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          elem_d     = din;
          swap_cnt_d = '0;
          idx_d      = '0;
          pass_d     = '0;
          flag_d     = 1'b0;
          state_d    = SORT;
        end else begin
          state_d    = IDLE;
        end
      end

      SORT: begin
        if (bout) begin
          elem_d[idx_q]   = cmp_in1;
          elem_d[idx_nxt] = cmp_in2;
          flag_d          = 1'b1;
          if (swap_cnt_q != {SWAP_W{1'b1}}) begin
            swap_cnt_d = swap_cnt_q + SWAP_W'(1);
          end
        end

        if (idx_q == (LAST_PASS - pass_q)) begin
          // The swap from this final compare still counts toward the pass flag.
          if (!(flag_q || bout) || (pass_q == LAST_PASS)) begin
            state_d = DONE;
            dout_d  = elem_d;
            swaps_d = swap_cnt_d;
          end else begin
            pass_d  = pass_q + IDX_W'(1);
            idx_d   = '0;
            flag_d  = 1'b0;
          end
        end else begin
          idx_d = idx_nxt;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      elem_q     <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      flag_q     <= 1'b0;
      swap_cnt_q <= '0;
      dout_q     <= '0;
      swaps_q    <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      flag_q     <= flag_d;
      swap_cnt_q <= swap_cnt_d;
      dout_q     <= dout_d;
      swaps_q    <= swaps_d;
    end
  end

  assign busy  = (state_q == SORT);
  assign done  = (state_q == DONE);
  assign dout  = dout_q;
  assign swaps = swaps_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_sort_ctrl.sv
// ----------------------------------------------------------------------------
// Module      : tb_nibble_sort_ctrl
// Description : Directed self-checking bench for nibble_sort_ctrl (N=4, W=4).
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nibble_sort_ctrl;

  localparam int N      = 4;
  localparam int W      = 4;
  localparam int SWAP_W = 8;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              start = 1'b0;
  logic [N*W-1:0]    din   = '0;
  logic              busy;
  logic              done;
  logic [N*W-1:0]    dout;
  logic [SWAP_W-1:0] swaps;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_sort_ctrl #(.N(N), .W(W), .SWAP_W(SWAP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .swaps (swaps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a vector for one accept edge, then scrambles din; returns in the
  // first cycle after the accept edge.
  task automatic start_sort(input logic [N*W-1:0] v);
    @(negedge clk);
    din   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din   = 16'hA5C3;
  endtask

  // Called in the first cycle after the accept edge.
  task automatic expect_sort(input string tag, input logic [N*W-1:0] exp_dout,
                             input int exp_swaps, input int exp_c,
                             input logic [N*W-1:0] prev_dout);
    for (int j = 0; j < exp_c; j++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_lo"}, 32'(done), 32'd0);
      chk({tag, "_dout_hold"}, 32'(dout), 32'(prev_dout));
      @(negedge clk);
    end
    chk({tag, "_done_hi"}, 32'(done), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    chk({tag, "_swaps"}, 32'(swaps), 32'(exp_swaps));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // T1: reset state and quiet idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_dout", 32'(dout), 32'h0000);
    chk("t1_swaps", 32'(swaps), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_no_done", 32'(done), 32'd0);
      chk("t1_no_busy", 32'(busy), 32'd0);
    end

    // T2: already sorted
    start_sort(16'h4321);
    expect_sort("t2", 16'h4321, 0, 3, 16'h0000);

    // T3: reverse order
    start_sort(16'h1234);
    expect_sort("t3", 16'h4321, 6, 6, 16'h4321);

    // T4: duplicates and all-equal
    start_sort(16'h0F0F);
    expect_sort("t4a", 16'hFF00, 3, 6, 16'h4321);
    start_sort(16'h5555);
    expect_sort("t4b", 16'h5555, 0, 3, 16'hFF00);

    // T5: start held through SORT, din changed mid-sort, back-to-back accept in DONE
    @(negedge clk);
    din   = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    din   = 16'h00FF;
    for (int j = 0; j < 6; j++) begin
      chk("t5_busy", 32'(busy), 32'd1);
      chk("t5_done_lo", 32'(done), 32'd0);
      if (j == 3) din = 16'h4321;
      @(negedge clk);
    end
    chk("t5_done_hi", 32'(done), 32'd1);
    chk("t5_busy_lo", 32'(busy), 32'd0);
    chk("t5_dout", 32'(dout), 32'h4321);
    chk("t5_swaps", 32'(swaps), 32'd6);
    @(negedge clk);
    start = 1'b0;
    din   = 16'hA5C3;
    expect_sort("t5b", 16'h4321, 0, 3, 16'h4321);

    // T6: reset in the third SORT cycle, then a fresh sort
    @(negedge clk);
    din = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_dout", 32'(dout), 32'h0000);
    chk("t6_swaps", 32'(swaps), 32'd0);
    @(negedge clk);
    chk("t6_still_idle", 32'(busy), 32'd0);
    chk("t6_no_done", 32'(done), 32'd0);
    start_sort(16'h4321);
    expect_sort("t6b", 16'h4321, 0, 3, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
